// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge
//   Memory-side responder for the D$ line-request interface. One request at a
//   time: a refill becomes a single AXI4 INCR read burst, a writeback becomes a
//   single AXI4 INCR write burst. The result (refilled line, or the written line
//   echoed back, plus an error flag) is returned on a valid/ready channel.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o      D$ request handshake (ready only in IDLE)
//   req_we_i                       1 = writeback, 0 = refill
//   req_addr_i                     line address, offset bits ignored
//   req_data_i                     writeback line data
//   resp_valid_o / resp_ready_i    response handshake
//   resp_data_o                    line buffer contents
//   resp_err_o                     non-OKAY rresp/bresp or rlast mismatch seen
//   m_axi_ar* / m_axi_r*           AXI4 read address / read data channels
//   m_axi_aw* / m_axi_w* / m_axi_b* AXI4 write address / data / response channels
module dcache_axi_bridge #(
   parameter int unsigned             ADDR_WIDTH     = 32,
   parameter int unsigned             LINE_BYTES     = 64,
   parameter int unsigned             AXI_DATA_WIDTH = 32,
   parameter int unsigned             AXI_ID_WIDTH   = 4,
   parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   // D$ request
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_we_i,
   input  logic [ADDR_WIDTH-1:0]         req_addr_i,
   input  logic [LINE_BYTES*8-1:0]       req_data_i,
   // D$ response
   output logic                          resp_valid_o,
   input  logic                          resp_ready_i,
   output logic [LINE_BYTES*8-1:0]       resp_data_o,
   output logic                          resp_err_o,
   // AXI read address
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [7:0]                    m_axi_arlen,
   output logic [2:0]                    m_axi_arsize,
   output logic [1:0]                    m_axi_arburst,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
   // AXI read data
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rlast,
   // AXI write address
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
   output logic [7:0]                    m_axi_awlen,
   output logic [2:0]                    m_axi_awsize,
   output logic [1:0]                    m_axi_awburst,
   output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
   // AXI write data
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                          m_axi_wlast,
   // AXI write response
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   input  logic [1:0]                    m_axi_bresp
);

   localparam int unsigned LINE_W = LINE_BYTES * 8;
   localparam int unsigned BEATS  = LINE_W / AXI_DATA_WIDTH;
   localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [LINE_W-1:0]       line_q;
   logic [CNT_W-1:0]        beat_q;
   logic                    err_q;
   logic                    last_beat;

   assign last_beat = (beat_q == CNT_W'(BEATS - 1));

   // Burst shape is fixed by the parameters: always one whole line.
   assign m_axi_araddr  = addr_q;
   assign m_axi_arlen   = 8'(BEATS - 1);
   assign m_axi_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
   assign m_axi_arburst = 2'b01;
   assign m_axi_arid    = AXI_ID;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = 8'(BEATS - 1);
   assign m_axi_awsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
   assign m_axi_awburst = 2'b01;
   assign m_axi_awid    = AXI_ID;
   assign m_axi_wdata   = line_q[beat_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   assign m_axi_wstrb   = '1;
   assign resp_data_o   = line_q;
   assign resp_err_o    = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Every valid/ready output is a pure decode of the state register, so all
   // of them drop to their idle values the instant reset asserts.
   always_comb begin
      state_d       = state_q;
      req_ready_o   = 1'b0;
      resp_valid_o  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) state_d = req_we_i ? S_AW : S_AR;
         end
         S_AR: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_d = S_R;
         end
         S_R: begin
            // Beat count, not rlast, ends the burst; a bad rlast only flags err.
            m_axi_rready = 1'b1;
            if (m_axi_rvalid && last_beat) state_d = S_RESP;
         end
         S_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_d = S_W;
         end
         S_W: begin
            m_axi_wvalid = 1'b1;
            m_axi_wlast  = last_beat;
            if (m_axi_wready && last_beat) state_d = S_B;
         end
         S_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
         line_q <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (req_valid_i) begin
               addr_q <= req_addr_i & ~ADDR_WIDTH'(LINE_BYTES - 1);
               beat_q <= '0;
               err_q  <= 1'b0;
               if (req_we_i) line_q <= req_data_i;
            end
            S_R: if (m_axi_rvalid) begin
               line_q[beat_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= m_axi_rdata;
               if ((m_axi_rresp != 2'b00) || (m_axi_rlast != last_beat)) err_q <= 1'b1;
               beat_q <= beat_q + 1'b1;
            end
            S_W: if (m_axi_wready) beat_q <= beat_q + 1'b1;
            S_B: if (m_axi_bvalid && (m_axi_bresp != 2'b00)) err_q <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
module tb_dcache_axi_bridge;
   localparam int A_W   = 32;
   localparam int LB    = 64;
   localparam int D_W   = 32;
   localparam int I_W   = 4;
   localparam int LW    = LB * 8;
   localparam int BEATS = LW / D_W;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic            req_valid_i = 0, req_ready_o, req_we_i = 0;
   logic [A_W-1:0]  req_addr_i = '0;
   logic [LW-1:0]   req_data_i = '0;
   logic            resp_valid_o, resp_ready_i = 0, resp_err_o;
   logic [LW-1:0]   resp_data_o;
   logic            m_axi_arvalid, m_axi_arready = 0;
   logic [A_W-1:0]  m_axi_araddr;
   logic [7:0]      m_axi_arlen;
   logic [2:0]      m_axi_arsize;
   logic [1:0]      m_axi_arburst;
   logic [I_W-1:0]  m_axi_arid;
   logic            m_axi_rvalid = 0, m_axi_rready, m_axi_rlast = 0;
   logic [D_W-1:0]  m_axi_rdata = '0;
   logic [1:0]      m_axi_rresp = '0;
   logic            m_axi_awvalid, m_axi_awready = 0;
   logic [A_W-1:0]  m_axi_awaddr;
   logic [7:0]      m_axi_awlen;
   logic [2:0]      m_axi_awsize;
   logic [1:0]      m_axi_awburst;
   logic [I_W-1:0]  m_axi_awid;
   logic            m_axi_wvalid, m_axi_wready = 0, m_axi_wlast;
   logic [D_W-1:0]  m_axi_wdata;
   logic [D_W/8-1:0] m_axi_wstrb;
   logic            m_axi_bvalid = 0, m_axi_bready;
   logic [1:0]      m_axi_bresp = '0;

   dcache_axi_bridge dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arid(m_axi_arid),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
      .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awid(m_axi_awid),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
      .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
   );

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_vec = 0, n_err = 0;
   int unsigned hs_cyc;
   // slave behaviour knobs
   int max_stall = 0, hold_cyc = 0, r_err_beat = -1, rlast_at = BEATS - 1, abort_beat = -1;
   logic [1:0] r_err_resp = 2'b00, b_resp_v = 2'b00;

   task automatic chk(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_ready"}, req_ready_o, 1'b1);
      chk({tag, "_valids"}, {resp_valid_o, m_axi_arvalid, m_axi_rready, m_axi_awvalid,
                             m_axi_wvalid, m_axi_bready}, 6'b0);
   endtask

   task automatic send_req(input logic we, input logic [A_W-1:0] addr, input logic [LW-1:0] data);
      int n;
      n = 0;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = data;
      while (!req_ready_o && n < 50) begin @(negedge clk_i); n++; end
      chk("req_accept", req_ready_o, 1'b1);
      hs_cyc = cyc;
      @(negedge clk_i);
      req_valid_i = 1'b0; req_data_i = '0;
      chk("req_ready_busy", req_ready_o, 1'b0);
   endtask

   task automatic finish_resp(input logic [LW-1:0] exp_line, input logic exp_err, input int exp_lat);
      int n;
      n = 0;
      resp_ready_i = 1'b0;
      while (!resp_valid_o && n < 200) begin @(negedge clk_i); n++; end
      chk("resp_valid", resp_valid_o, 1'b1);
      if (exp_lat > 0) chk("latency", cyc - hs_cyc, exp_lat);
      for (int h = 0; h < hold_cyc; h++) begin
         @(negedge clk_i);
         chk("resp_held", {resp_valid_o, resp_err_o}, {1'b1, exp_err});
         chk("resp_held_data", resp_data_o, exp_line);
      end
      chk("resp_data", resp_data_o, exp_line);
      chk("resp_err", resp_err_o, exp_err);
      resp_ready_i = 1'b1;
      @(negedge clk_i);
      resp_ready_i = 1'b0;
      chk("back_idle", {req_ready_o, resp_valid_o}, 2'b10);
   endtask

   task automatic do_refill(input logic [A_W-1:0] addr, input bit fixed, input logic [31:0] base);
      logic [D_W-1:0] w [BEATS];
      logic [LW-1:0]  exp_line;
      logic [A_W-1:0] exp_addr;
      logic           exp_err;
      int n;
      exp_addr = addr & ~A_W'(LB - 1);
      for (int k = 0; k < BEATS; k++) begin
         w[k] = fixed ? base + k : $urandom;
         exp_line[k*D_W +: D_W] = w[k];
      end
      exp_err = (r_err_beat >= 0 && r_err_resp != 2'b00) || (rlast_at != BEATS - 1);
      send_req(1'b0, addr, {LW/32{$urandom}});
      n = 0;
      while (!m_axi_arvalid && n < 50) begin @(negedge clk_i); n++; end
      chk("arvalid", m_axi_arvalid, 1'b1);
      chk("araddr", m_axi_araddr, exp_addr);
      chk("ar_len_size_burst_id", {m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid},
          {8'(BEATS - 1), 3'd2, 2'b01, 4'd0});
      repeat ($urandom_range(max_stall, 0)) begin
         @(negedge clk_i);
         chk("ar_stall_hold", {m_axi_arvalid, m_axi_araddr}, {1'b1, exp_addr});
      end
      m_axi_arready = 1'b1;
      @(negedge clk_i);
      m_axi_arready = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         if (k == abort_beat) begin
            rst_ni = 1'b0;
            #1;
            idle_outputs("abort");
            chk("abort_clear", {resp_err_o, resp_data_o}, '0);
            @(negedge clk_i);
            rst_ni = 1'b1;
            abort_beat = -1;
            return;
         end
         repeat ($urandom_range(max_stall, 0)) @(negedge clk_i);
         m_axi_rvalid = 1'b1; m_axi_rdata = w[k];
         m_axi_rresp = (k == r_err_beat) ? r_err_resp : 2'b00;
         m_axi_rlast = (k == rlast_at);
         n = 0;
         while (!m_axi_rready && n < 50) begin @(negedge clk_i); n++; end
         chk("rready", m_axi_rready, 1'b1);
         @(negedge clk_i);
         m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end
      finish_resp(exp_line, exp_err, (max_stall == 0) ? 2 + BEATS : 0);
   endtask

   task automatic do_wb(input logic [A_W-1:0] addr, input logic [LW-1:0] line);
      logic [A_W-1:0] exp_addr;
      int n;
      exp_addr = addr & ~A_W'(LB - 1);
      send_req(1'b1, addr, line);
      n = 0;
      while (!m_axi_awvalid && n < 50) begin @(negedge clk_i); n++; end
      chk("awvalid", m_axi_awvalid, 1'b1);
      chk("awaddr", m_axi_awaddr, exp_addr);
      chk("aw_len_size_burst_id", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid},
          {8'(BEATS - 1), 3'd2, 2'b01, 4'd0});
      chk("no_w_before_aw", m_axi_wvalid, 1'b0);
      repeat ($urandom_range(max_stall, 0)) begin
         @(negedge clk_i);
         chk("aw_stall_hold", {m_axi_awvalid, m_axi_awaddr, m_axi_wvalid}, {1'b1, exp_addr, 1'b0});
      end
      m_axi_awready = 1'b1;
      @(negedge clk_i);
      m_axi_awready = 1'b0;
      for (int k = 0; k < BEATS; k++) begin
         repeat ($urandom_range(max_stall, 0)) begin
            @(negedge clk_i);
            chk("w_stall_hold", {m_axi_wvalid, m_axi_wdata}, {1'b1, line[k*D_W +: D_W]});
         end
         m_axi_wready = 1'b1;
         n = 0;
         while (!m_axi_wvalid && n < 50) begin @(negedge clk_i); n++; end
         chk("wdata", m_axi_wdata, line[k*D_W +: D_W]);
         chk("wstrb_wlast", {m_axi_wstrb, m_axi_wlast}, {4'hF, 1'(k == BEATS - 1)});
         @(negedge clk_i);
         m_axi_wready = 1'b0;
      end
      chk("w_done", m_axi_wvalid, 1'b0);
      repeat ($urandom_range(max_stall, 0)) begin
         @(negedge clk_i);
         chk("no_resp_before_b", resp_valid_o, 1'b0);
      end
      m_axi_bvalid = 1'b1; m_axi_bresp = b_resp_v;
      n = 0;
      while (!m_axi_bready && n < 50) begin @(negedge clk_i); n++; end
      chk("bready", m_axi_bready, 1'b1);
      @(negedge clk_i);
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
      finish_resp(line, b_resp_v != 2'b00, 0);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   initial begin
      logic [LW-1:0] inc_line;
      @(negedge clk_i);
      idle_outputs("reset");
      chk("reset_data_err", {resp_err_o, resp_data_o}, '0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // zero-wait refill with beat k = 0xA0 + k
      do_refill(32'h0000_1234, 1'b1, 32'hA0);

      // writeback of incrementing bytes (beat0 = 0x03020100)
      for (int i = 0; i < LB; i++) inc_line[i*8 +: 8] = 8'(i);
      chk("inc_beat0", inc_line[31:0], 32'h0302_0100);
      do_wb(32'h8000_0040, inc_line);

      // random traffic with stalls on every channel
      max_stall = 5;
      for (int t = 0; t < 12; t++) begin
         hold_cyc = $urandom_range(3, 0);
         if ($urandom_range(1, 0) == 1) do_wb($urandom, rand_line());
         else                           do_refill($urandom, 1'b0, 32'h0);
      end

      // error responses, then a clean request clears the flag
      max_stall = 1; hold_cyc = 0;
      r_err_beat = 7; r_err_resp = 2'b10;
      do_refill($urandom, 1'b0, 32'h0);
      r_err_beat = -1; r_err_resp = 2'b00;
      b_resp_v = 2'b11;
      do_wb($urandom, rand_line());
      b_resp_v = 2'b00;
      do_refill($urandom, 1'b0, 32'h0);

      // early rlast at beat 10, response held off for 4 cycles
      rlast_at = 10; hold_cyc = 4;
      do_refill($urandom, 1'b0, 32'h0);
      rlast_at = BEATS - 1; hold_cyc = 0;

      // reset in the middle of the read burst, then a fresh refill
      abort_beat = 5;
      do_refill(32'h0000_4480, 1'b0, 32'h0);
      max_stall = 0;
      do_refill(32'h0000_4480, 1'b1, 32'h5500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
